// File: rtl/snn_pkg.sv
// Shared definitions for the tinysnn neuron scheduler.
//   state_t        : scheduler FSM states (also exported on the debug port)
//   *_DEF          : default LIF constants (threshold, leak shift, refractory)
//   sat_add()      : unsigned add clamped to an arbitrary result width
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int THRESH_DEF     = 200;
  localparam int LEAK_SHIFT_DEF = 3;
  localparam int REFRAC_DEF     = 2;

  // Adds a and b and clamps the result to 2^w - 1. The 33-bit sum keeps the
  // carry so a wrap can never hide an overflow.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [31:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = 32'((64'd1 << w) - 64'd1);
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire update for one neuron.
//   v, inn, refrac          : current membrane, input current, refractory count
//   v_next, refrac_next     : state to write back
//   spike                   : neuron fires this timestep
// While refractory the neuron is clamped at 0 and ignores its input.
module lif_update
  import snn_pkg::*;
#(
  parameter int W          = 8,
  parameter int THRESH     = THRESH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int REFRAC     = REFRAC_DEF,
  parameter int RW         = 2
) (
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  inn,
  input  logic [RW-1:0] refrac,
  output logic [W-1:0]  v_next,
  output logic [RW-1:0] refrac_next,
  output logic          spike
);

  localparam logic [W-1:0] THR = W'(THRESH);

  logic [W-1:0] leaked;
  logic [31:0]  sum32;
  logic [W-1:0] s;
  logic         unused_sat_hi;

  // v - (v >> LEAK_SHIFT) never underflows, so only the input add can overflow.
  assign leaked        = v - (v >> LEAK_SHIFT);
  assign sum32         = sat_add(32'(leaked), 32'(inn), W);
  assign s             = sum32[W-1:0];
  assign unused_sat_hi = ^sum32[31:W];

  always_comb begin
    v_next      = v;
    refrac_next = refrac;
    spike       = 1'b0;
    if (refrac != '0) begin
      refrac_next = refrac - RW'(1);
      v_next      = '0;
    end else if (s >= THR) begin
      spike       = 1'b1;
      v_next      = '0;
      refrac_next = RW'(REFRAC);
    end else begin
      v_next      = s;
    end
  end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed timestep scheduler for the tinysnn neuron array.
// On tick_i (in IDLE) the input currents are latched and every neuron is
// walked through one shared lif_update datapath, one neuron per cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   tick_i            : start-of-timestep strobe (only honoured in IDLE)
//   inn_i             : packed input currents, neuron k at [k*W +: W]
//   busy_o            : high whenever not IDLE
//   done_o            : one-cycle pulse in DONE
//   spike_valid_o     : spike event pending, spike_id_o : its neuron index
//   spike_ready_i     : consumer accepts the pending spike event
//   spike_vec_o       : spikes of the last completed timestep
//   overrun_o         : sticky, tick_i seen while busy
//   dbg_state_o       : current FSM state
//
// Spike handshake: spike_valid_o rises the cycle after a firing UPDATE and
// stays high, with spike_id_o stable, until the rising edge on which
// spike_ready_i is also high; that edge is the transfer. Every output is a
// flop, so spike_ready_i has no combinational path to any output.
module snn_neuron_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int W           = 8,
  parameter int THRESH      = THRESH_DEF,
  parameter int LEAK_SHIFT  = LEAK_SHIFT_DEF,
  parameter int REFRAC      = REFRAC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick_i,
  input  logic [NUM_NEURONS*W-1:0]       inn_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           spike_valid_o,
  input  logic                           spike_ready_i,
  output logic [$clog2(NUM_NEURONS)-1:0] spike_id_o,
  output logic [NUM_NEURONS-1:0]         spike_vec_o,
  output logic                           overrun_o,
  output state_t                         dbg_state_o
);

  localparam int IW = $clog2(NUM_NEURONS);
  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_NEURONS - 1);

  state_t                   state_q;
  logic [IW-1:0]            idx_q;
  logic [NUM_NEURONS*W-1:0] inn_q;
  logic [NUM_NEURONS-1:0]   scratch_q;
  logic [W-1:0]             v_q      [NUM_NEURONS];
  logic [RW-1:0]            refrac_q [NUM_NEURONS];

  // Shared datapath: state registers are muxed by idx.
  logic [W-1:0]  v_cur, inn_cur, v_nxt;
  logic [RW-1:0] refrac_cur, refrac_nxt;
  logic          spike;

  assign v_cur      = v_q[idx_q];
  assign refrac_cur = refrac_q[idx_q];
  assign inn_cur    = inn_q[idx_q*W +: W];

  lif_update #(
    .W          (W),
    .THRESH     (THRESH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .RW         (RW)
  ) u_lif (
    .v           (v_cur),
    .inn         (inn_cur),
    .refrac      (refrac_cur),
    .v_next      (v_nxt),
    .refrac_next (refrac_nxt),
    .spike       (spike)
  );

  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      inn_q         <= '0;
      scratch_q     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      spike_valid_o <= 1'b0;
      spike_id_o    <= '0;
      spike_vec_o   <= '0;
      overrun_o     <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k]      <= '0;
        refrac_q[k] <= '0;
      end
    end else begin
      // A tick in any busy state, DONE included, is dropped and flagged.
      if (tick_i && (state_q != ST_IDLE)) begin
        overrun_o <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick_i) begin
            inn_q     <= inn_i;
            scratch_q <= '0;
            idx_q     <= '0;
            busy_o    <= 1'b1;
            state_q   <= ST_UPDATE;
          end
        end

        ST_UPDATE: begin
          v_q[idx_q]      <= v_nxt;
          refrac_q[idx_q] <= refrac_nxt;
          if (spike) begin
            scratch_q[idx_q] <= 1'b1;
            spike_id_o       <= idx_q;
            spike_valid_o    <= 1'b1;
            state_q          <= ST_EMIT;
          end else if (idx_q == LAST) begin
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end

        ST_EMIT: begin
          if (spike_ready_i) begin
            spike_valid_o <= 1'b0;
            if (idx_q == LAST) begin
              done_o  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= ST_UPDATE;
            end
          end
        end

        ST_DONE: begin
          done_o      <= 1'b0;
          busy_o      <= 1'b0;
          spike_vec_o <= scratch_q;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
module tb_snn_neuron_scheduler;
  import snn_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           tick_i        = 1'b0;
  logic [N*W-1:0] inn_i         = '0;
  logic           spike_ready_i = 1'b0;
  logic           busy_o, done_o, spike_valid_o, overrun_o;
  logic [IW-1:0]  spike_id_o;
  logic [N-1:0]   spike_vec_o;
  state_t         dbg_state;

  snn_neuron_scheduler #(.NUM_NEURONS(N), .W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .inn_i         (inn_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .spike_valid_o (spike_valid_o),
    .spike_ready_i (spike_ready_i),
    .spike_id_o    (spike_id_o),
    .spike_vec_o   (spike_vec_o),
    .overrun_o     (overrun_o),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int stall_cycles = 0;
  int wait_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Spike consumer: holds ready low for stall_cycles cycles per event, and
  // checks every observed id against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spike_ready_i = 1'b0;
        wait_cnt      = 0;
      end else if (spike_valid_o) begin
        if (exp_q.size() == 0) begin
          check("extra_spike", 32'(spike_valid_o), 32'd0);
          spike_ready_i = 1'b1;
        end else begin
          check("spike_id", 32'(spike_id_o), 32'(exp_q[0]));
          if (wait_cnt >= stall_cycles) begin
            spike_ready_i = 1'b1;
            void'(exp_q.pop_front());
            wait_cnt = 0;
          end else begin
            spike_ready_i = 1'b0;
            wait_cnt++;
          end
        end
      end else begin
        spike_ready_i = (stall_cycles == 0);
        wait_cnt      = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one timestep. pulse_mask bit c drives tick_i during cycle c after
  // the accepting edge. exp_lat counts cycles from the tick edge to done_o.
  task automatic run_tick(input logic [N*W-1:0] inn, input int exp_lat,
                          input logic [N-1:0] exp_vec, input logic [31:0] pulse_mask);
    int lat;
    logic found;
    @(negedge clk);
    tick_i = 1'b1;
    inn_i  = inn;
    @(posedge clk);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 200) begin
      @(negedge clk);
      lat++;
      tick_i = pulse_mask[lat % 32];
      if (lat == 1) check("busy_high", 32'(busy_o), 32'd1);
      if (done_o) found = 1'b1;
    end
    check("done_seen", 32'(found), 32'd1);
    if (found) check("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    tick_i = 1'b0;
    check("done_pulse", 32'(done_o), 32'd0);
    check("busy_low", 32'(busy_o), 32'd0);
    check("spike_vec", 32'(spike_vec_o), 32'(exp_vec));
    check("pending_spikes", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int v0_exp [6] = '{100, 188, 0, 0, 0, 100};
  int rf_exp [6] = '{0, 0, 2, 1, 0, 0};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_valid", 32'(spike_valid_o), 32'd0);
    check("rst_vec", 32'(spike_vec_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    stall_cycles = 0;

    // All-zero inputs: no spikes, done 5 cycles after the tick edge
    run_tick('0, 5, 4'b0000, 32'd0);

    // inn0 = 100: 100, 188, 255 -> spike, refractory x2, 100
    for (int t = 0; t < 6; t++) begin
      if (t == 2) begin
        exp_q.push_back(8'd0);
        run_tick(32'd100, 6, 4'b0001, 32'd0);
      end else begin
        run_tick(32'd100, 5, 4'b0000, 32'd0);
      end
      check($sformatf("v0_t%0d", t + 1), 32'(dut.v_q[0]), 32'(v0_exp[t]));
      check($sformatf("rf0_t%0d", t + 1), 32'(dut.refrac_q[0]), 32'(rf_exp[t]));
    end

    // All inputs saturate, 3 stall cycles per event
    stall_cycles = 3;
    for (int k = 0; k < N; k++) exp_q.push_back(W'(k));
    run_tick({N{8'd255}}, 21, 4'b1111, 32'd0);
    check("rf3_after_all", 32'(dut.refrac_q[3]), 32'd2);
    stall_cycles = 0;

    // Burn off refractory, then tick during UPDATE (cycle 1) and EMIT (cycle 3)
    run_tick('0, 5, 4'b0000, 32'd0);
    run_tick('0, 5, 4'b0000, 32'd0);
    check("overrun_before", 32'(overrun_o), 32'd0);
    exp_q.push_back(8'd1);
    run_tick(32'h0000_FF00, 6, 4'b0010, 32'b1010);
    check("overrun_set", 32'(overrun_o), 32'd1);
    repeat (3) @(negedge clk);
    check("no_extra_step", 32'(busy_o), 32'd0);
    check("overrun_sticky", 32'(overrun_o), 32'd1);

    // Reset while stalled in EMIT
    stall_cycles = 1000;
    exp_q.push_back(8'd0);
    @(negedge clk);
    tick_i = 1'b1;
    inn_i  = {N{8'd255}};
    @(posedge clk);
    @(negedge clk);
    tick_i = 1'b0;
    @(negedge clk);
    check("emit_valid", 32'(spike_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", 32'(spike_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_vec", 32'(spike_vec_o), 32'd0);
    check("arst_overrun", 32'(overrun_o), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("arst_rf0", 32'(dbg_state == ST_IDLE ? dut.refrac_q[0] : 2'd3), 32'd0);
    repeat (2) @(negedge clk);
    stall_cycles = 0;
    rst_n = 1'b1;
    run_tick(32'd100, 5, 4'b0000, 32'd0);
    check("v0_after_rst", 32'(dut.v_q[0]), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_neuron_scheduler.md
# snn_neuron_scheduler

Time-multiplexed timestep scheduler for the tinysnn neuron array. On each `tick_i` it latches one 8-bit input current per virtual neuron and walks all neurons through a single shared leaky-integrate-and-fire (LIF) update datapath, one neuron per cycle. Membrane and refractory state live in on-block registers. Spikes are emitted as id events over a valid/ready handshake, and a per-timestep spike vector is published at the end of each timestep.

## Interface
- `NUM_NEURONS`, 4: virtual neurons served; power of two, 2..16.
- `W`, 8: membrane and input width.
- `THRESH`, 200: fire when updated membrane ≥ `THRESH`.
- `LEAK_SHIFT`, 3: leak term = v >> `LEAK_SHIFT`.
- `REFRAC`, 2: timesteps a neuron is held after firing.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `tick_i`  in  1  start-timestep strobe; sampled only in IDLE.
- `inn_i`  in  NUM_NEURONS*W  input currents; neuron k at [k*W +: W]; latched on the accepting edge.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse in DONE.
- `spike_valid_o`  out  1  spike event pending.
- `spike_ready_i`  in  1  consumer accepts the event.
- `spike_id_o`  out  $clog2(NUM_NEURONS)  index of the firing neuron.
- `spike_vec_o`  out  NUM_NEURONS  spikes of the last completed timestep.
- `overrun_o`  out  1  sticky: `tick_i` seen while busy; cleared only by reset.

## Operation
- The FSM has four states: IDLE, UPDATE, EMIT, DONE.
- IDLE: when `tick_i`=1, latch `inn_i` and go to UPDATE with idx=0. The scratch spike vector is cleared on the same edge.
- UPDATE: the LIF update for neuron idx is computed and written back on the edge. Outcomes on that edge:
  - spike: bit idx is set in the scratch vector, `spike_id_o`←idx, and the state goes to EMIT.
  - no spike, idx ≠ N−1: idx+1, stay in UPDATE.
  - no spike, idx = N−1: go to DONE.
- EMIT: `spike_valid_o`=1. `spike_id_o` is held stable until `spike_valid_o` && `spike_ready_i`. On the handshake edge, go to UPDATE with idx+1, or to DONE if idx = N−1.
- DONE: `done_o`=1 for one cycle. `spike_vec_o`←scratch vector on the exit edge, then go to IDLE.
- LIF update, computed in W+1 bits:
  - If refrac>0: refrac−1, v stays 0, no spike, input ignored.
  - Otherwise: s = v − (v>>LEAK_SHIFT) + inn, saturated to 2^W−1.
  - If s ≥ THRESH: spike, v←0, refrac←REFRAC. Else v←s.
- `tick_i` in any non-IDLE state is ignored and sets `overrun_o`. A tick in the DONE cycle is also ignored.
- Reset: every output is 0, all membranes and refrac counters are 0, latched inputs are 0, state is IDLE. Asserting reset mid-timestep aborts immediately; the partial scratch vector is discarded.

## Timing
- Tick accepted at edge 0 → UPDATE for neuron k occupies cycle k+1 when no earlier neuron fired.
- Latency, tick edge → `done_o` high: N+1 cycles + one EMIT cycle per spike + stall cycles while `spike_ready_i`=0.
- The earliest next tick is accepted in the cycle after DONE.
- `spike_valid_o` rises in the cycle after the firing UPDATE cycle.
- Spike ids within a timestep are emitted in strictly ascending order.
- A combinational path from `spike_ready_i` to any output is forbidden.

## Structure
- Shared package `snn_pkg` holds:
  - the FSM state enum;
  - default constants for THRESH, LEAK_SHIFT and REFRAC;
  - the saturating-add helper function.
- Sub-module `lif_update` is purely combinational:
  - inputs: v, inn, refrac;
  - outputs: v_next, refrac_next, spike.
- `lif_update` is instantiated once and shared across neurons through idx-muxed state registers.

## Test plan
All scenarios use defaults (N=4, THRESH=200, LEAK_SHIFT=3, REFRAC=2).
- Reset, then tick with all inn=0 → no `spike_valid_o`; `done_o` high exactly 5 cycles after the tick edge; `spike_vec_o`=4'b0000.
- inn0=100, others 0, six ticks:
  - v0 = 100, then 188, then 265 saturating to 255 → spike id 0 on tick 3;
  - ticks 4 and 5: no spike, v0 = 0;
  - tick 6: v0 = 100.
- All inn=255, `spike_ready_i` low for 3 cycles on each event:
  - ids 0,1,2,3 are emitted in order, with valid and id stable during stalls;
  - `done_o` arrives 4+1+4+12 = 21 cycles after the tick;
  - `spike_vec_o`=4'b1111.
- Tick pulsed during UPDATE and during EMIT → `overrun_o`=1 and stays 1; timestep results are unchanged and no extra timestep runs.
- rst_n low during EMIT:
  - all outputs are 0 asynchronously, and `overrun_o` is cleared;
  - on release, inn0=100 gives v0=100 after one tick, proving membrane state was cleared.
